// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and saturating bubble/flush counters.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic             id_MemRead,
    input  logic [4:0]       id_ALUOp,
    input  logic             id_ALUSrc,
    input  logic [1:0]       id_WDSel,
    input  logic [2:0]       id_DMType,
    input  logic             id_sbtype,
    input  logic             id_jal,
    input  logic             id_jalr,
    input  logic             flush,
    input  logic             hold,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic             ex_RegWrite,
    output logic             ex_MemWrite,
    output logic             ex_MemRead,
    output logic [4:0]       ex_ALUOp,
    output logic             ex_ALUSrc,
    output logic [1:0]       ex_WDSel,
    output logic [2:0]       ex_DMType,
    output logic             ex_sbtype,
    output logic             ex_jal,
    output logic             ex_jalr,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic [4:0]      alu_op;
        logic            alu_src;
        logic [1:0]      wd_sel;
        logic [2:0]      dm_type;
        logic            sbtype;
        logic            jal;
        logic            jalr;
    } slot_t;

    slot_t ex_q;
    slot_t id_pkt;
    logic  load_use;

    always_comb begin
        id_pkt           = '0;
        id_pkt.valid     = id_valid;
        id_pkt.pc        = id_pc;
        id_pkt.rs1_data  = id_rs1_data;
        id_pkt.rs2_data  = id_rs2_data;
        id_pkt.imm       = id_imm;
        id_pkt.rs1       = id_rs1;
        id_pkt.rs2       = id_rs2;
        id_pkt.rd        = id_rd;
        id_pkt.reg_write = id_RegWrite;
        id_pkt.mem_write = id_MemWrite;
        id_pkt.mem_read  = id_MemRead;
        id_pkt.alu_op    = id_ALUOp;
        id_pkt.alu_src   = id_ALUSrc;
        id_pkt.wd_sel    = id_WDSel;
        id_pkt.dm_type   = id_DMType;
        id_pkt.sbtype    = id_sbtype;
        id_pkt.jal       = id_jal;
        id_pkt.jalr      = id_jalr;
    end

    // x0 as load destination never hazards; an empty decode slot never hazards.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
                   ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
        stall_id = ~rst & (hold | (load_use & ~flush));
    end

    // A bubble is the all-zero slot: invalid, no side effects, ALUOp nop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q       <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (!hold) begin
            if (flush) begin
                ex_q <= '0;
                if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
            end else if (load_use) begin
                ex_q <= '0;
                if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
            end else if (id_valid) begin
                ex_q <= id_pkt;
            end else begin
                ex_q <= '0;
            end
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_RegWrite = ex_q.reg_write;
    assign ex_MemWrite = ex_q.mem_write;
    assign ex_MemRead  = ex_q.mem_read;
    assign ex_ALUOp    = ex_q.alu_op;
    assign ex_ALUSrc   = ex_q.alu_src;
    assign ex_WDSel    = ex_q.wd_sel;
    assign ex_DMType   = ex_q.dm_type;
    assign ex_sbtype   = ex_q.sbtype;
    assign ex_jal      = ex_q.jal;
    assign ex_jalr     = ex_q.jalr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W=2 so counter saturation is reachable).
module tb_id_ex_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_use_rs1, id_use_rs2;
    logic             id_RegWrite, id_MemWrite, id_MemRead;
    logic [4:0]       id_ALUOp;
    logic             id_ALUSrc;
    logic [1:0]       id_WDSel;
    logic [2:0]       id_DMType;
    logic             id_sbtype, id_jal, id_jalr;
    logic             flush, hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic             ex_RegWrite, ex_MemWrite, ex_MemRead;
    logic [4:0]       ex_ALUOp;
    logic             ex_ALUSrc;
    logic [1:0]       ex_WDSel;
    logic [2:0]       ex_DMType;
    logic             ex_sbtype, ex_jal, ex_jalr;
    logic             stall_id;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_RegWrite(id_RegWrite), .id_MemWrite(id_MemWrite), .id_MemRead(id_MemRead),
        .id_ALUOp(id_ALUOp), .id_ALUSrc(id_ALUSrc), .id_WDSel(id_WDSel),
        .id_DMType(id_DMType), .id_sbtype(id_sbtype), .id_jal(id_jal), .id_jalr(id_jalr),
        .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_MemRead(ex_MemRead), .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc),
        .ex_WDSel(ex_WDSel), .ex_DMType(ex_DMType), .ex_sbtype(ex_sbtype),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_id();
        id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
        id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_RegWrite = 0; id_MemWrite = 0; id_MemRead = 0; id_ALUOp = '0;
        id_ALUSrc = 0; id_WDSel = '0; id_DMType = '0; id_sbtype = 0; id_jal = 0; id_jalr = 0;
    endtask

    // lw rd, 0(rs1)
    task automatic drive_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [XLEN-1:0] pc);
        clear_id();
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rd = rd; id_use_rs1 = 1;
        id_rs1_data = 32'h0000_1000; id_RegWrite = 1; id_MemRead = 1;
        id_ALUOp = 5'd1; id_ALUSrc = 1; id_WDSel = 2'b01; id_DMType = 3'b010;
    endtask

    // R-type (use2=1) or I-type (use2=0, ALUSrc=1) ALU op
    task automatic drive_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic use2, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm);
        clear_id();
        id_valid = 1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = 1; id_use_rs2 = use2; id_RegWrite = 1; id_ALUOp = 5'd1;
        id_ALUSrc = ~use2; id_imm = imm; id_rs1_data = 32'h11; id_rs2_data = 32'h22;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        clear_id();
        flush = 0; hold = 0;

        // Reset with a pending hold and load present: rst wins, stall_id low.
        rst = 1; hold = 1; drive_lw(5'd5, 5'd1, 32'h50);
        settle();
        check("stall_during_rst", stall_id, 0);
        tick();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_pc", ex_pc, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        rst = 0; hold = 0;

        // 1: lw x5 then dependent add
        drive_lw(5'd5, 5'd1, 32'h100);
        settle();
        check("t1_lw_no_stall", stall_id, 0);
        tick();
        check("t1_lw_valid", ex_valid, 1);
        check("t1_lw_pc", ex_pc, 32'h100);
        check("t1_lw_memread", ex_MemRead, 1);
        check("t1_lw_wdsel", ex_WDSel, 2'b01);
        check("t1_lw_dmtype", ex_DMType, 3'b010);
        check("t1_lw_rs1_data", ex_rs1_data, 32'h1000);
        drive_alu(5'd6, 5'd5, 5'd2, 1, 32'h104, 0);
        settle();
        check("t1_stall", stall_id, 1);
        tick();
        check("t1_bubble_valid", ex_valid, 0);
        check("t1_bubble_regwrite", ex_RegWrite, 0);
        check("t1_bubble_rd", ex_rd, 0);
        check("t1_bubble_pc", ex_pc, 0);
        check("t1_bubble_cnt", bubble_cnt, 1);
        check("t1_stall_cleared", stall_id, 0);
        tick();
        check("t1_add_valid", ex_valid, 1);
        check("t1_add_pc", ex_pc, 32'h104);
        check("t1_add_rd", ex_rd, 6);
        check("t1_add_rs2", ex_rs2, 2);
        check("t1_add_rs2_data", ex_rs2_data, 32'h22);
        check("t1_bubble_cnt_hold", bubble_cnt, 1);

        // 2: lw x0 never hazards
        drive_lw(5'd0, 5'd1, 32'h200);
        tick();
        drive_alu(5'd6, 5'd0, 5'd2, 1, 32'h204, 0);
        settle();
        check("t2_no_stall", stall_id, 0);
        tick();
        check("t2_add_valid", ex_valid, 1);
        check("t2_add_pc", ex_pc, 32'h204);
        check("t2_bubble_cnt", bubble_cnt, 1);

        // 3: addi with rs2 field = 5 but unused
        drive_lw(5'd5, 5'd3, 32'h300);
        tick();
        drive_alu(5'd7, 5'd1, 5'd5, 0, 32'h304, 32'h5);
        settle();
        check("t3_no_stall", stall_id, 0);
        tick();
        check("t3_addi_pc", ex_pc, 32'h304);
        check("t3_addi_imm", ex_imm, 32'h5);
        check("t3_addi_alusrc", ex_ALUSrc, 1);
        check("t3_bubble_cnt", bubble_cnt, 1);

        // Invalid slot with hazard-looking fields behind a load: no stall, loads as bubble
        drive_lw(5'd5, 5'd3, 32'h380);
        tick();
        drive_alu(5'd6, 5'd5, 5'd5, 1, 32'h384, 32'h7);
        id_valid = 0;
        settle();
        check("inv_no_stall", stall_id, 0);
        tick();
        check("inv_valid", ex_valid, 0);
        check("inv_pc", ex_pc, 0);
        check("inv_imm", ex_imm, 0);
        check("inv_bubble_cnt", bubble_cnt, 1);

        // 4: flush and load_use together
        do_reset();
        drive_lw(5'd5, 5'd1, 32'h400);
        tick();
        drive_alu(5'd6, 5'd5, 5'd2, 1, 32'h404, 0);
        flush = 1;
        settle();
        check("t4_stall", stall_id, 0);
        tick();
        flush = 0;
        check("t4_valid", ex_valid, 0);
        check("t4_flush_cnt", flush_cnt, 1);
        check("t4_bubble_cnt", bubble_cnt, 0);

        // 5: hold for 3 cycles with flush asserted
        drive_alu(5'd8, 5'd1, 5'd2, 1, 32'h500, 0);
        tick();
        check("t5_pre_pc", ex_pc, 32'h500);
        drive_alu(5'd9, 5'd3, 5'd4, 1, 32'h504, 0);
        hold = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t5_hold_stall", stall_id, 1);
            tick();
            check("t5_hold_pc", ex_pc, 32'h500);
            check("t5_hold_rd", ex_rd, 8);
            check("t5_hold_valid", ex_valid, 1);
            check("t5_hold_flush_cnt", flush_cnt, 1);
            check("t5_hold_bubble_cnt", bubble_cnt, 0);
        end
        hold = 0; flush = 0;
        settle();
        check("t5_resume_stall", stall_id, 0);
        tick();
        check("t5_resume_pc", ex_pc, 32'h504);
        check("t5_resume_rd", ex_rd, 9);
        check("t5_resume_flush_cnt", flush_cnt, 1);

        // 6: saturation with CNT_W=2
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_lw(5'd5, 5'd1, 32'h600);
            tick();
            drive_alu(5'd6, 5'd5, 5'd2, 1, 32'h604, 0);
            tick();
            check("t6_bubble_cnt", bubble_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        check("t6_flush_cnt", flush_cnt, 0);

        // Reset mid-stall: everything clears, dependent add then flows in
        drive_lw(5'd5, 5'd1, 32'h700);
        tick();
        drive_alu(5'd6, 5'd5, 5'd2, 1, 32'h704, 0);
        rst = 1;
        settle();
        check("t6_rst_stall", stall_id, 0);
        tick();
        rst = 0;
        check("t6_rst_valid", ex_valid, 0);
        check("t6_rst_pc", ex_pc, 0);
        check("t6_rst_memread", ex_MemRead, 0);
        check("t6_rst_bubble_cnt", bubble_cnt, 0);
        check("t6_rst_flush_cnt", flush_cnt, 0);
        settle();
        check("t6_post_rst_stall", stall_id, 0);
        tick();
        check("t6_post_rst_pc", ex_pc, 32'h704);
        check("t6_post_rst_valid", ex_valid, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
